// File: rtl/vu_meter_pkg.sv
// Shared types and helpers for the multi-channel VU meter.
package vu_meter_pkg;

  localparam int unsigned LEVEL_W = 32;

  typedef enum logic {
    VU_BAR = 1'b0,
    VU_DOT = 1'b1
  } vu_mode_e;

  // Threshold k = base << (k*step_shift); once a shift would push a bit out the
  // result sticks at all-ones, which no level can strictly exceed.
  function automatic logic [LEVEL_W-1:0] vu_threshold(input logic [LEVEL_W-1:0] base,
                                                      input int unsigned step_shift,
                                                      input int unsigned k);
    logic [LEVEL_W-1:0] t;
    int unsigned        n;
    t = base;
    n = step_shift * k;
    for (int unsigned i = 0; i < LEVEL_W; i++) begin
      if (i < n) begin
        if (t[LEVEL_W-1]) t = '1;
        else              t = t << 1;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/vu_meter_multi_if.sv
// Sample-in / LED-out bundle between the I2S side and the VU meter.
interface vu_meter_multi_if #(
  parameter int SAMPLE_W = 24,
  parameter int NUM_CH   = 2,
  parameter int NUM_LEDS = 8
);
  logic                         sample_stb_i;
  logic [NUM_CH*SAMPLE_W-1:0]   samples_i;
  logic                         mode_i;
  logic                         peak_en_i;
  logic [NUM_CH*NUM_LEDS-1:0]   leds_o;
  logic                         tick_o;
  logic [NUM_CH-1:0]            clip_o;

  modport master (
    output sample_stb_i, samples_i, mode_i, peak_en_i,
    input  leds_o, tick_o, clip_o
  );

  modport slave (
    input  sample_stb_i, samples_i, mode_i, peak_en_i,
    output leds_o, tick_o, clip_o
  );
endinterface

// File: rtl/vu_channel.sv
// One VU channel: magnitude, attack/decay envelope, bar count, peak hold and
// LED encoding, all refreshed on the display tick.
module vu_channel
  import vu_meter_pkg::*;
#(
  parameter int SAMPLE_W      = 24,
  parameter int NUM_LEDS      = 8,
  parameter int DECAY_SHIFT   = 11,
  parameter int SCALE_SHIFT   = 8,
  parameter int TH_BASE       = 1000,
  parameter int TH_STEP_SHIFT = 1,
  parameter int HOLD_TICKS    = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sample_stb_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                tick_i,
  input  logic                mode_i,
  input  logic                peak_en_i,
  output logic [NUM_LEDS-1:0] leds_o,
  output logic                clip_o
);

  localparam int CNT_W  = $clog2(NUM_LEDS + 1);
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] mag;
  logic                sat;
  logic [LEVEL_W-1:0]  scaled;
  logic [LEVEL_W-1:0]  level;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    peak, peak_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic [NUM_LEDS-1:0] leds_nxt;

  // The most-negative code has no positive twin, so it clamps to full scale.
  always_comb begin
    sat = (sample_i == S_MIN);
    if (sat)                      mag = ~S_MIN;
    else if (sample_i[SAMPLE_W-1]) mag = ~sample_i + SAMPLE_W'(1);
    else                          mag = sample_i;
    scaled = LEVEL_W'(mag >> SCALE_SHIFT);
  end

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < NUM_LEDS; k++) begin
      if (level > vu_threshold(LEVEL_W'(TH_BASE), TH_STEP_SHIFT, k)) cnt = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    peak_nxt = peak;
    hold_nxt = hold;
    if (cnt >= peak) begin
      peak_nxt = cnt;
      hold_nxt = HOLD_W'(HOLD_TICKS);
    end else if (hold != '0) begin
      hold_nxt = hold - HOLD_W'(1);
    end else begin
      peak_nxt = peak - CNT_W'(1);
    end
  end

  always_comb begin
    leds_nxt = '0;
    for (int unsigned k = 0; k < NUM_LEDS; k++) begin
      if (vu_mode_e'(mode_i) == VU_BAR) leds_nxt[k] = (CNT_W'(k) < cnt);
      else                              leds_nxt[k] = (CNT_W'(k + 1) == cnt);
      if (peak_en_i && (CNT_W'(k + 1) == peak_nxt)) leds_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level  <= '0;
      peak   <= '0;
      hold   <= '0;
      leds_o <= '0;
      clip_o <= 1'b0;
    end else begin
      if (sample_stb_i) begin
        if (scaled > level) level <= scaled;
        else                level <= level - (level >> DECAY_SHIFT);
      end
      if (tick_i) begin
        peak   <= peak_nxt;
        hold   <= hold_nxt;
        leds_o <= leds_nxt;
      end
      if (sample_stb_i && sat) clip_o <= 1'b1;
      else if (tick_i)         clip_o <= 1'b0;
    end
  end

endmodule

// File: rtl/vu_meter_multi.sv
// NUM_CH-channel VU meter: shared display-tick divider plus one vu_channel per
// channel, packed onto the LED bank.
module vu_meter_multi #(
  parameter int SAMPLE_W      = 24,
  parameter int NUM_CH        = 2,
  parameter int NUM_LEDS      = 8,
  parameter int DECAY_SHIFT   = 11,
  parameter int SCALE_SHIFT   = 8,
  parameter int TH_BASE       = 1000,
  parameter int TH_STEP_SHIFT = 1,
  parameter int HOLD_TICKS    = 20,
  parameter int LED_DIV       = 540000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vu_meter_multi_if.slave bus
);

  localparam int DIV_W = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

  logic [DIV_W-1:0]           div_q;
  logic                       tick_pulse;
  logic                       tick_q;
  logic [NUM_CH*NUM_LEDS-1:0] leds;
  logic [NUM_CH-1:0]          clip;

  // Channels commit on the same edge that raises tick_o, so leds_o and
  // tick_o change together.
  assign tick_pulse = (div_q == DIV_W'(LED_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_pulse;
      div_q  <= tick_pulse ? '0 : div_q + DIV_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vu_channel #(
      .SAMPLE_W     (SAMPLE_W),
      .NUM_LEDS     (NUM_LEDS),
      .DECAY_SHIFT  (DECAY_SHIFT),
      .SCALE_SHIFT  (SCALE_SHIFT),
      .TH_BASE      (TH_BASE),
      .TH_STEP_SHIFT(TH_STEP_SHIFT),
      .HOLD_TICKS   (HOLD_TICKS)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sample_stb_i(bus.sample_stb_i),
      .sample_i    (bus.samples_i[c*SAMPLE_W +: SAMPLE_W]),
      .tick_i      (tick_pulse),
      .mode_i      (bus.mode_i),
      .peak_en_i   (bus.peak_en_i),
      .leds_o      (leds[c*NUM_LEDS +: NUM_LEDS]),
      .clip_o      (clip[c])
    );
  end

  assign bus.leds_o = leds;
  assign bus.tick_o = tick_q;
  assign bus.clip_o = clip;

endmodule

// File: tb/tb_vu_meter_multi.sv
// Scoreboard bench for vu_meter_multi: stimulus queues the expected display per
// tick, a monitor compares whenever tick_o is high.
module tb_vu_meter_multi;

  localparam int SW = 24;
  localparam int NC = 2;
  localparam int NL = 8;

  typedef struct {
    string       name;
    logic [15:0] leds;
    logic [1:0]  clip_b;
    logic [1:0]  clip_a;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] clip_prev = 2'b00;

  always #5 clk = ~clk;

  vu_meter_multi_if #(.SAMPLE_W(SW), .NUM_CH(NC), .NUM_LEDS(NL)) bus ();

  vu_meter_multi #(
    .SAMPLE_W  (SW),
    .NUM_CH    (NC),
    .NUM_LEDS  (NL),
    .HOLD_TICKS(2),
    .LED_DIV   (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [15:0] leds,
                      input logic [1:0] cb, input logic [1:0] ca);
    exp_t e;
    e.name = name; e.leds = leds; e.clip_b = cb; e.clip_a = ca;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [23:0] c0, input logic [23:0] c1);
    bus.sample_stb_i = 1'b1;
    bus.samples_i    = {c1, c0};
    @(posedge clk); #1;
    bus.sample_stb_i = 1'b0;
    bus.samples_i    = '0;
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.tick_o !== 1'b1 && n < 8);
    if (bus.tick_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no tick within %0d cycles, required a tick", name, n);
    end
  endtask

  task automatic expect_tick(input string name, input logic [15:0] leds,
                             input logic [1:0] cb, input logic [1:0] ca);
    push(name, leds, cb, ca);
    wait_tick(name);
  endtask

  // Monitor: clip is compared just before the tick edge and just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tick_o === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tick: got tick with empty queue, required none");
        end else begin
          e = q.pop_front();
          check({e.name, "_leds"},   32'(bus.leds_o), 32'(e.leds));
          check({e.name, "_clip_b"}, 32'(clip_prev),  32'(e.clip_b));
          check({e.name, "_clip_a"}, 32'(bus.clip_o), 32'(e.clip_a));
        end
      end
      clip_prev = bus.clip_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bus.sample_stb_i = 1'b1;
    bus.samples_i    = {24'h800000, 24'h0BB800};
    bus.mode_i       = 1'b0;
    bus.peak_en_i    = 1'b1;
    rst = 1'b1;
    idle(3);
    check("rst_leds", 32'(bus.leds_o), 32'h0);
    check("rst_clip", 32'(bus.clip_o), 32'h0);
    check("rst_tick", 32'(bus.tick_o), 32'h0);
    bus.sample_stb_i = 1'b0;
    bus.samples_i    = '0;
    push("t1_after_reset", 16'h0000, 2'b00, 2'b00);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.tick_o !== 1'b1 && n < 10);
    check("first_tick_cycle", 32'(n), 32'd4);

    // ch0 scaled 3000 -> two thresholds passed
    strobe(24'h0BB800, 24'h000000);
    expect_tick("t2_bar", 16'h0003, 2'b00, 2'b00);

    // ch0 negative full scale clips; ch1 positive full scale does not
    strobe(24'h800000, 24'h7FFFFF);
    expect_tick("t3_fullscale", 16'h3F3F, 2'b01, 2'b00);

    // saturating strobe on the tick edge: set beats clear
    push("t4_clip_setwins", 16'h3F3F, 2'b00, 2'b01);
    idle(3);
    strobe(24'h800000, 24'h000000);
    check("t4_align", 32'(bus.tick_o), 32'h1);
    expect_tick("t5_clip_clear", 16'h3F3F, 2'b01, 2'b00);

    // reset mid-display discards level, peak and divider phase
    rst = 1'b1;
    idle(1);
    check("midrst_leds", 32'(bus.leds_o), 32'h0);
    check("midrst_clip", 32'(bus.clip_o), 32'h0);
    check("midrst_tick", 32'(bus.tick_o), 32'h0);
    idle(1);
    push("t6_post_reset", 16'h0000, 2'b00, 2'b00);
    rst = 1'b0;
    wait_tick("t6_post_reset");

    // level 16010 -> cnt 5; two zero strobes decay by 7 each to 15996 -> cnt 4
    strobe(24'h3E8A00, 24'h000000);
    expect_tick("t7_peak5", 16'h001F, 2'b00, 2'b00);
    strobe(24'h000000, 24'h000000);
    strobe(24'h000000, 24'h000000);
    bus.mode_i = 1'b1;
    expect_tick("t8_dot_hold1", 16'h0018, 2'b00, 2'b00);
    bus.peak_en_i = 1'b0;
    expect_tick("t9_dot_nopeak", 16'h0008, 2'b00, 2'b00);
    bus.peak_en_i = 1'b1;
    expect_tick("t10_peak_fall", 16'h0008, 2'b00, 2'b00);
    bus.mode_i = 1'b0;
    expect_tick("t11_bar_track", 16'h000F, 2'b00, 2'b00);

    // ch1 strobe on the tick edge shows up one tick later
    push("t12_coincident", 16'h000F, 2'b00, 2'b00);
    idle(3);
    strobe(24'h000000, 24'h0BB800);
    check("t12_align", 32'(bus.tick_o), 32'h1);
    expect_tick("t13_after_coinc", 16'h030F, 2'b00, 2'b00);

    idle(2);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
